multicycle_controller: RTL and testbench

Multi-cycle sequencer for the LEGv8 subset core: ADD, SUB, AND, ORR, LDUR, STUR, CBZ and B. It replaces single-cycle decode with a state machine that steps each instruction through fetch, decode, execute, memory and writeback. It also arbitrates a single shared instruction/data memory port between instruction fetch and load/store access. It sits between the instruction register, register file, ALU, PC logic and the unified memory.

---
 rtl/multicycle_controller.sv | 181 ++++++++++++++++++
 tb/tb_multicycle_controller.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// Multi-cycle LEGv8 sequencer: fetch/decode/execute/memory/writeback FSM sharing one memory port.
// Optional memory timeout fault enabled by defining MULTICYCLE_CTRL_MEM_TIMEOUT_EN.
module multicycle_controller #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] ir,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        ADDR_SEL,
  output logic        IR_WRITE,
  output logic        PC_WRITE,
  output logic        REG2LOC,
  output logic        ALU_SRC,
  output logic        MEM2REG,
  output logic        REG_WRITE,
  output logic [1:0]  PC_SRC,
  output logic [1:0]  ALU_OP,
  output logic        fault,
  output logic [31:0] retired
);

  typedef enum logic [3:0] {
    IDLE, FETCH, DECODE, EX_R, EX_ADDR, MEM_RD, MEM_WR,
    WB_R, WB_LD, EX_CBZ, EX_B, HALT
  } state_t;

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [7:0]  OP_CBZ  = 8'b10110100;
  localparam logic [5:0]  OP_B    = 6'b000101;

  state_t      state_q, state_d;
  logic        fault_q;
  logic [31:0] retired_q;
  logic        retire;
  logic [20:0] unused_ir;

  assign unused_ir = ir[20:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

`ifdef MULTICYCLE_CTRL_MEM_TIMEOUT_EN
  logic [4:0] tmo_cnt;
  logic       tmo_hit;

  assign tmo_hit = mem_req && !mem_ready && (tmo_cnt == 5'(MEM_TIMEOUT - 1));

  // Cleared on entry to any memory-access state so each access gets a full budget.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      tmo_cnt <= '0;
    else if ((state_d != state_q) &&
             (state_d == FETCH || state_d == MEM_RD || state_d == MEM_WR))
      tmo_cnt <= '0;
    else if (mem_req && !mem_ready)
      tmo_cnt <= tmo_cnt + 5'd1;
  end
`else
  localparam int unsigned unused_mem_timeout = MEM_TIMEOUT;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = FETCH;
      FETCH:   if (mem_ready) state_d = DECODE;
      DECODE: begin
        if (ir[31:24] == OP_CBZ)
          state_d = EX_CBZ;
        else if (ir[31:26] == OP_B)
          state_d = EX_B;
        else if (ir[31:21] == OP_ADD || ir[31:21] == OP_SUB ||
                 ir[31:21] == OP_AND || ir[31:21] == OP_ORR)
          state_d = EX_R;
        else if (ir[31:21] == OP_LDUR || ir[31:21] == OP_STUR)
          state_d = EX_ADDR;
        else
          state_d = HALT;
      end
      EX_R:    state_d = WB_R;
      WB_R:    state_d = FETCH;
      EX_ADDR: state_d = (ir[31:21] == OP_LDUR) ? MEM_RD : MEM_WR;
      MEM_RD:  if (mem_ready) state_d = WB_LD;
      MEM_WR:  if (mem_ready) state_d = FETCH;
      WB_LD:   state_d = FETCH;
      EX_CBZ:  state_d = FETCH;
      EX_B:    state_d = FETCH;
      HALT:    state_d = HALT;
      default: state_d = HALT;
    endcase
`ifdef MULTICYCLE_CTRL_MEM_TIMEOUT_EN
    if (tmo_hit) state_d = HALT;
`endif
  end

  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    ADDR_SEL  = 1'b0;
    IR_WRITE  = 1'b0;
    PC_WRITE  = 1'b0;
    REG2LOC   = 1'b0;
    ALU_SRC   = 1'b0;
    MEM2REG   = 1'b0;
    REG_WRITE = 1'b0;
    PC_SRC    = 2'b00;
    ALU_OP    = 2'b00;
    case (state_q)
      FETCH: begin
        mem_req  = 1'b1;
        // IR/PC only load when the fetch actually completes.
        IR_WRITE = mem_ready;
        PC_WRITE = mem_ready;
      end
      EX_R: ALU_OP = 2'b10;
      WB_R: begin
        REG_WRITE = 1'b1;
        ALU_OP    = 2'b10;
      end
      EX_ADDR: begin
        ALU_SRC = 1'b1;
        REG2LOC = (ir[31:21] == OP_STUR);
      end
      MEM_RD: begin
        mem_req  = 1'b1;
        ADDR_SEL = 1'b1;
        ALU_SRC  = 1'b1;
      end
      MEM_WR: begin
        mem_req  = 1'b1;
        mem_we   = 1'b1;
        ADDR_SEL = 1'b1;
        ALU_SRC  = 1'b1;
        REG2LOC  = 1'b1;
      end
      WB_LD: begin
        REG_WRITE = 1'b1;
        MEM2REG   = 1'b1;
      end
      EX_CBZ: begin
        REG2LOC  = 1'b1;
        ALU_OP   = 2'b01;
        PC_WRITE = zero;
        PC_SRC   = 2'b01;
      end
      EX_B: begin
        PC_WRITE = 1'b1;
        PC_SRC   = 2'b10;
      end
      default: ;
    endcase
  end

  assign retire = (state_q == WB_R) || (state_q == WB_LD) || (state_q == EX_CBZ) ||
                  (state_q == EX_B) || ((state_q == MEM_WR) && mem_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault_q   <= 1'b0;
      retired_q <= '0;
    end else begin
      fault_q <= fault_q || (state_d == HALT);
      if (retire) retired_q <= retired_q + 32'd1;
    end
  end

  assign fault   = fault_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed table-driven bench for multicycle_controller, plus hand sequences for
// halt, asynchronous reset during a memory wait and the optional memory timeout.
module tb_multicycle_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] ir;
  logic        zero;
  logic        mem_ready;
  logic        mem_req, mem_we, ADDR_SEL, IR_WRITE, PC_WRITE, REG2LOC;
  logic        ALU_SRC, MEM2REG, REG_WRITE;
  logic [1:0]  PC_SRC, ALU_OP;
  logic        fault;
  logic [31:0] retired;

  multicycle_controller #(.MEM_TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .ir(ir), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .ADDR_SEL(ADDR_SEL), .IR_WRITE(IR_WRITE),
    .PC_WRITE(PC_WRITE), .REG2LOC(REG2LOC), .ALU_SRC(ALU_SRC), .MEM2REG(MEM2REG),
    .REG_WRITE(REG_WRITE), .PC_SRC(PC_SRC), .ALU_OP(ALU_OP), .fault(fault),
    .retired(retired)
  );

  always #5 clk = ~clk;

  // Control bundle bit layout: {req,we,addr_sel,irw,pcw,r2l,alu_src,m2r,rw,pc_src[1:0],alu_op[1:0]}
  localparam logic [12:0] K_REQ  = 13'h1000;
  localparam logic [12:0] K_WE   = 13'h0800;
  localparam logic [12:0] K_AS   = 13'h0400;
  localparam logic [12:0] K_IRW  = 13'h0200;
  localparam logic [12:0] K_PCW  = 13'h0100;
  localparam logic [12:0] K_R2L  = 13'h0080;
  localparam logic [12:0] K_ASRC = 13'h0040;
  localparam logic [12:0] K_M2R  = 13'h0020;
  localparam logic [12:0] K_RW   = 13'h0010;
  localparam logic [12:0] K_PB   = 13'h0008;
  localparam logic [12:0] K_PCBZ = 13'h0004;
  localparam logic [12:0] K_AFN  = 13'h0002;
  localparam logic [12:0] K_APAS = 13'h0001;
  localparam logic [12:0] K_FET  = K_REQ | K_IRW | K_PCW;

  localparam logic [31:0] I_ADD  = 32'h8B030041;
  localparam logic [31:0] I_AND  = 32'h8A030041;
  localparam logic [31:0] I_LDUR = 32'hF8400041;
  localparam logic [31:0] I_STUR = 32'hF8000041;
  localparam logic [31:0] I_CBZ  = 32'hB4000021;
  localparam logic [31:0] I_B    = 32'h14000002;

  typedef struct {
    logic [31:0] ir;
    logic        zero;
    logic        rdy;
    logic [12:0] ctrl;
    logic        flt;
    logic [31:0] ret;
  } vec_t;

  vec_t vecs[$];
  int   tests = 0;
  int   fails = 0;

  function automatic void add(input logic [31:0] i_ir, input logic z, input logic r,
                              input logic [12:0] c, input logic f, input logic [31:0] rt);
    vec_t v;
    v.ir = i_ir; v.zero = z; v.rdy = r; v.ctrl = c; v.flt = f; v.ret = rt;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s[%0d]: got 0x%0h, expected 0x%0h", name, idx, act, exp);
    end
  endtask

  function automatic logic [12:0] ctrl_now();
    return {mem_req, mem_we, ADDR_SEL, IR_WRITE, PC_WRITE, REG2LOC, ALU_SRC,
            MEM2REG, REG_WRITE, PC_SRC, ALU_OP};
  endfunction

  initial begin
    int n;
    rst_n = 1'b0; ir = '0; zero = 1'b0; mem_ready = 1'b0;

    // Trace starts in IDLE right after reset release.
    add(I_ADD,  0, 1, '0, 0, 0);
    add(I_ADD,  0, 1, K_FET, 0, 0);
    add(I_ADD,  0, 1, '0, 0, 0);
    add(I_ADD,  0, 1, K_AFN, 0, 0);
    add(I_ADD,  0, 1, K_RW | K_AFN, 0, 0);
    add(I_LDUR, 0, 1, K_FET, 0, 1);
    add(I_LDUR, 0, 1, '0, 0, 1);
    add(I_LDUR, 0, 1, K_ASRC, 0, 1);
    add(I_LDUR, 0, 0, K_REQ | K_AS | K_ASRC, 0, 1);
    add(I_LDUR, 0, 0, K_REQ | K_AS | K_ASRC, 0, 1);
    add(I_LDUR, 0, 0, K_REQ | K_AS | K_ASRC, 0, 1);
    add(I_LDUR, 0, 1, K_REQ | K_AS | K_ASRC, 0, 1);
    add(I_LDUR, 0, 1, K_RW | K_M2R, 0, 1);
    add(I_STUR, 0, 1, K_FET, 0, 2);
    add(I_STUR, 0, 1, '0, 0, 2);
    add(I_STUR, 0, 1, K_ASRC | K_R2L, 0, 2);
    add(I_STUR, 0, 1, K_REQ | K_WE | K_AS | K_ASRC | K_R2L, 0, 2);
    add(I_CBZ,  1, 1, K_FET, 0, 3);
    add(I_CBZ,  1, 1, '0, 0, 3);
    add(I_CBZ,  1, 1, K_R2L | K_APAS | K_PCW | K_PCBZ, 0, 3);
    add(I_CBZ,  0, 1, K_FET, 0, 4);
    add(I_CBZ,  0, 1, '0, 0, 4);
    add(I_CBZ,  0, 1, K_R2L | K_APAS | K_PCBZ, 0, 4);
    add(I_B,    0, 1, K_FET, 0, 5);
    add(I_B,    0, 1, '0, 0, 5);
    add(I_B,    0, 1, K_PCW | K_PB, 0, 5);
    add(I_AND,  0, 1, K_FET, 0, 6);
    add(I_AND,  0, 1, '0, 0, 6);
    add(I_AND,  0, 1, K_AFN, 0, 6);
    add(I_AND,  0, 1, K_RW | K_AFN, 0, 6);
    add('0,     0, 0, K_REQ, 0, 7);
    add('0,     0, 1, K_FET, 0, 7);
    add('0,     0, 1, '0, 0, 7);
    add('0,     0, 1, '0, 1, 7);

    repeat (2) @(negedge clk);
    #1;
    chk("reset_ctrl", 0, 32'(ctrl_now()), 0);
    chk("reset_fault", 0, 32'(fault), 0);
    chk("reset_retired", 0, retired, 0);

    @(negedge clk);
    rst_n = 1'b1;
    foreach (vecs[i]) begin
      if (i > 0) @(negedge clk);
      ir = vecs[i].ir; zero = vecs[i].zero; mem_ready = vecs[i].rdy;
      #1;
      chk("ctrl", i, 32'(ctrl_now()), 32'(vecs[i].ctrl));
      chk("fault", i, 32'(fault), 32'(vecs[i].flt));
      chk("retired", i, retired, vecs[i].ret);
    end

    // HALT is terminal: no memory requests, fault stays set.
    n = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk); #1;
      if (mem_req) n++;
    end
    chk("halt_req_cycles", 0, n, 0);
    chk("halt_fault", 0, 32'(fault), 1);

    #1 rst_n = 1'b0;
    #1;
    chk("rst_clear_fault", 0, 32'(fault), 0);
    chk("rst_clear_retired", 0, retired, 0);

    // Reset in the middle of a fetch wait drops mem_req without a clock edge.
    @(negedge clk);
    rst_n = 1'b1; mem_ready = 1'b0;
    @(negedge clk); #1;
    chk("wait_req", 0, 32'(mem_req), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_drop_req", 0, 32'(mem_req), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_idle", 0, 32'(mem_req), 0);

    n = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk); #1;
      if (fault) break;
      if (mem_req) n++;
    end
`ifdef MULTICYCLE_CTRL_MEM_TIMEOUT_EN
    chk("timeout_wait_cycles", 0, n, 16);
    chk("timeout_fault", 0, 32'(fault), 1);
    chk("timeout_req_dropped", 0, 32'(mem_req), 0);
`else
    chk("no_timeout_wait_cycles", 0, n, 100);
    chk("no_timeout_fault", 0, 32'(fault), 0);
    chk("no_timeout_req", 0, 32'(mem_req), 1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
